score_packer: RTL



---
 rtl/score_packer_pkg.sv | 19 +
 rtl/score_packer_if.sv | 32 +++
 rtl/score_packer.sv | 81 ++++++++
 3 files changed

// File: rtl/score_packer_pkg.sv
// Constants and state encoding shared by score_packer and the downstream argmax stage.
// The index width bounds DATA_NUM to 256 lanes.
package score_packer_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DATA_NUM   = 16;
   localparam int IDX_W          = 8;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } pack_state_e;

   // fill_count must be able to report DATA_NUM itself, which needs one extra bit at 256
   function automatic int fill_w(input int n);
      return (n >= (1 << IDX_W)) ? IDX_W + 1 : IDX_W;
   endfunction

endpackage

// File: rtl/score_packer_if.sv
// Beat-in / frame-out bundle between the score source, score_packer and the argmax consumer.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid and ready are
// both high; valid, once raised, holds its payload until that edge, and ready never depends on valid.
interface score_packer_if #(
   parameter int DATA_WIDTH = score_packer_pkg::DEF_DATA_WIDTH,
   parameter int DATA_NUM   = score_packer_pkg::DEF_DATA_NUM
);
   import score_packer_pkg::*;

   localparam int CNT_W = fill_w(DATA_NUM);

   logic [DATA_WIDTH-1:0]          in_data;
   logic                           in_valid;
   logic                           in_last;
   logic                           in_ready;
   logic [DATA_WIDTH*DATA_NUM-1:0] data_out;
   logic                           out_valid;
   logic                           out_ready;
   logic [CNT_W-1:0]               fill_count;
   logic                           frame_err;

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, data_out, out_valid, fill_count, frame_err
   );

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, data_out, out_valid, fill_count, frame_err
   );

endinterface

// File: rtl/score_packer.sv
// Packs serial score beats into one wide frame, lane 0 first, and holds it until the consumer takes it.
// Short frames and frames missing in_last are still delivered, flagged by a one-cycle frame_err.
module score_packer #(
   parameter int DATA_WIDTH = score_packer_pkg::DEF_DATA_WIDTH,
   parameter int DATA_NUM   = score_packer_pkg::DEF_DATA_NUM
) (
   input  logic                              clk,
   input  logic                              rst,
   score_packer_if.slave                     bus,
   output score_packer_pkg::pack_state_e     state_dbg
);
   import score_packer_pkg::*;

   localparam int FW    = DATA_WIDTH * DATA_NUM;
   localparam int CNT_W = fill_w(DATA_NUM);
   localparam int OFS_W = $clog2(FW);
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(DATA_NUM - 1);

   pack_state_e       state_q, state_d;
   logic [FW-1:0]     data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              beat;
   logic              full_lane;
   logic [OFS_W-1:0]  wr_ofs;

   // Ready/valid come from the state register only; rst forces both low while it is held
   assign bus.in_ready   = (state_q == FILL) && !rst;
   assign bus.out_valid  = (state_q == HOLD) && !rst;
   assign bus.data_out   = data_q;
   assign bus.fill_count = cnt_q;
   assign bus.frame_err  = err_q;
   assign state_dbg      = state_q;

   assign beat      = bus.in_ready && bus.in_valid;
   assign full_lane = (cnt_q == LAST_LANE);
   assign wr_ofs    = OFS_W'(cnt_q) * OFS_W'(DATA_WIDTH);

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      case (state_q)
         FILL: begin
            if (beat) begin
               data_d[wr_ofs +: DATA_WIDTH] = bus.in_data;
               cnt_d = cnt_q + CNT_W'(1);
               // The frame closes on in_last or on the final lane; only both together is well-formed
               if (full_lane || bus.in_last) begin
                  state_d = HOLD;
                  err_d   = !(full_lane && bus.in_last);
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d = FILL;
               data_d  = '0;
               cnt_d   = '0;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         data_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

endmodule
